// File: rtl/cnnip_mem_pkg.sv
// Shared types and width helpers for the multi-port CNN IP buffer memory.
package cnnip_mem_pkg;

    localparam int unsigned MEM_NUM_PORTS  = 4;
    localparam int unsigned MEM_DATA_WIDTH = 32;

    function automatic int unsigned be_width(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MEM_PORT_W = idx_width(MEM_NUM_PORTS);

    // One stage of the read-return pipeline
    typedef struct packed {
        logic                      valid;
        logic [MEM_PORT_W-1:0]     port;
        logic [MEM_DATA_WIDTH-1:0] data;
    } rd_slot_t;

endpackage

// File: rtl/cnnip_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the rotating pointer.
module cnnip_rr_arbiter
    import cnnip_mem_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    localparam int unsigned PIW       = idx_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_grant_c,
    output logic [PIW-1:0]       o_grant_idx_c,
    output logic                 o_grant_vld_c
);

    logic [PIW-1:0] r_ptr;
    logic [PIW-1:0] w_cand;

    // First requester at or after the pointer, wrapping around
    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        o_grant_vld_c = 1'b0;
        w_cand        = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_cand = PIW'((32'(r_ptr) + k) % NUM_PORTS);
            if (!o_grant_vld_c && i_req[w_cand]) begin
                o_grant_c[w_cand] = 1'b1;
                o_grant_idx_c     = w_cand;
                o_grant_vld_c     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_grant_vld_c) begin
            r_ptr <= PIW'((32'(o_grant_idx_c) + 1) % NUM_PORTS);
        end
    end

endmodule

// File: rtl/cnnip_mem_mp.sv
// Multi-port block memory: round-robin shared single-port RAM with byte writes
// and fixed-latency read return routed back to the requesting port.
module cnnip_mem_mp
    import cnnip_mem_pkg::*;
#(
    parameter  int unsigned NUM_PORTS    = MEM_NUM_PORTS,
    parameter  int unsigned ADDR_WIDTH   = 16,
    parameter  int unsigned DATA_WIDTH   = MEM_DATA_WIDTH,
    parameter  int unsigned DEPTH        = 4096,
    parameter  int unsigned READ_LATENCY = 2,
    localparam int unsigned BE           = be_width(DATA_WIDTH),
    localparam int unsigned PIW          = idx_width(NUM_PORTS),
    localparam int unsigned MIW          = idx_width(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req_en,
    input  logic [NUM_PORTS-1:0][BE-1:0]          req_we,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_din,
    output logic [NUM_PORTS-1:0]                  req_ready,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_dout,
    output logic [NUM_PORTS-1:0]                  rsp_valid
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_grant;
    logic [PIW-1:0]        w_gidx;
    logic                  w_gvld;
    logic [BE-1:0]         w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_in_range;
    logic [MIW-1:0]        w_mem_idx;

    rd_slot_t r_pipe [READ_LATENCY];
    rd_slot_t w_slot_in;
    rd_slot_t w_slot_out;
    logic [NUM_PORTS-1:0]  w_hit;

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rsp_dout;
    logic [NUM_PORTS-1:0]                 r_rsp_valid;

    // No grants while reset is held
    assign w_req = req_en & {NUM_PORTS{~rst}};

    cnnip_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_req),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_gidx),
        .o_grant_vld_c (w_gvld)
    );

    assign req_ready  = w_grant;
    assign w_we       = req_we[w_gidx];
    assign w_addr     = req_addr[w_gidx];
    assign w_din      = req_din[w_gidx];
    assign w_in_range = 32'(w_addr) < DEPTH;
    assign w_mem_idx  = MIW'(w_addr);
    assign w_rd_data  = w_in_range ? r_mem[w_mem_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_gvld && (w_we != '0) && w_in_range) begin
            for (int unsigned k = 0; k < BE; k++) begin
                if (w_we[k]) begin
                    r_mem[w_mem_idx][k*8 +: 8] <= w_din[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_slot_in       = '0;
        w_slot_in.valid = w_gvld && (w_we == '0);
        w_slot_in.port  = MEM_PORT_W'(w_gidx);
        w_slot_in.data  = MEM_DATA_WIDTH'(w_rd_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_slot_in;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_slot_out = r_pipe[READ_LATENCY-1];

    always_comb begin
        w_hit = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_hit[p] = w_slot_out.valid && (w_slot_out.port == MEM_PORT_W'(p));
        end
    end

    // Per-port response registers; dout holds until that port's next response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_dout  <= '0;
        end else begin
            r_rsp_valid <= w_hit;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (w_hit[p]) begin
                    r_rsp_dout[p] <= DATA_WIDTH'(w_slot_out.data);
                end
            end
        end
    end

    assign rsp_dout  = r_rsp_dout;
    assign rsp_valid = r_rsp_valid;

    a_dw_bytes:     assert property (@(posedge clk) (DATA_WIDTH % 8) == 0);
    a_latency:      assert property (@(posedge clk) READ_LATENCY >= 1);
    a_slot_fit:     assert property (@(posedge clk) (DATA_WIDTH == MEM_DATA_WIDTH) && (PIW <= MEM_PORT_W));
    a_grant_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
